frv_mem_arbiter: RTL and testbench

Two-requester memory port arbiter that merges the core's instruction (imem) and data (dmem) memory interfaces onto a single shared req/gnt/recv/ack memory bus. It sits between `frv_core` and a single-ported memory or interconnect. It selects and locks one requester per bus transaction and records the owner of every issued transaction. It routes in-order responses back to the correct requester.

---
 rtl/frv_mem_arbiter_pkg.sv | 24 ++
 rtl/frv_mem_arb_fifo.sv | 63 ++++++
 rtl/frv_mem_arbiter.sv | 141 ++++++++++++++
 tb/tb_frv_mem_arbiter.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/frv_mem_arbiter_pkg.sv
// Shared constants and types for the frv_mem_arbiter slice: owner encodings,
// the outstanding-transaction ceiling and the request field bundle.
package frv_mem_arbiter_pkg;

    localparam logic FRV_MEM_ARB_D = 1'b0;
    localparam logic FRV_MEM_ARB_I = 1'b1;

    localparam int FRV_MEM_ARB_MAX_OUTSTANDING = 4;
    localparam int CNT_W = 3;
    localparam int PTR_W = 2;

    typedef struct packed {
        logic        wen;
        logic [3:0]  strb;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_req_t;

    // Pointer increment that wraps at an arbitrary depth of 1..4.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr, input int depth);
        return (int'(ptr) == depth - 1) ? '0 : ptr + 1'b1;
    endfunction

endpackage

// File: rtl/frv_mem_arb_fifo.sv
// One-bit-wide owner FIFO recording which requester owns each in-flight bus
// transaction; depth set by DEPTH (1..4).
module frv_mem_arb_fifo
    import frv_mem_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic             g_clk,
    input  logic             g_resetn,
    input  logic             push,
    input  logic             push_data,
    input  logic             pop,
    output logic             head,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic [FRV_MEM_ARB_MAX_OUTSTANDING-1:0] slots;
    logic pop_ok;

    assign pop_ok = pop && (count_reg != '0);

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= ptr_inc(wr_ptr_reg, DEPTH);
            end
            if (pop_ok) begin
                rd_ptr_reg <= ptr_inc(rd_ptr_reg, DEPTH);
            end
            if (push && !pop_ok) begin
                count_reg <= count_reg + 1'b1;
            end else if (pop_ok && !push) begin
                count_reg <= count_reg - 1'b1;
            end
        end
    end

    // Storage needs no reset: a slot is only read back after it has been pushed.
    generate
        for (genvar gi = 0; gi < FRV_MEM_ARB_MAX_OUTSTANDING; gi++) begin : g_slot
            logic slot_reg;
            always_ff @(posedge g_clk) begin
                if (push && (wr_ptr_reg == PTR_W'(gi))) begin
                    slot_reg <= push_data;
                end
            end
            assign slots[gi] = slot_reg;
        end
    endgenerate

    assign head  = slots[rd_ptr_reg];
    assign empty = (count_reg == '0);
    assign count = count_reg;

endmodule

// File: rtl/frv_mem_arbiter.sv
// Merges the core's imem and dmem ports onto one req/gnt/recv/ack bus.
// Define FRV_MEM_ARB_RR_EN for round-robin; otherwise dmem has fixed priority.
module frv_mem_arbiter
    import frv_mem_arbiter_pkg::*;
#(
    parameter int OUTSTANDING = 2
) (
    input  logic        g_clk,
    input  logic        g_resetn,

    input  logic        d_req,
    input  logic        d_wen,
    input  logic [3:0]  d_strb,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_recv,
    output logic        d_error,
    output logic [31:0] d_rdata,
    input  logic        d_ack,

    input  logic        i_req,
    input  logic        i_wen,
    input  logic [3:0]  i_strb,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic        i_gnt,
    output logic        i_recv,
    output logic        i_error,
    output logic [31:0] i_rdata,
    input  logic        i_ack,

    output logic        m_req,
    output logic        m_wen,
    output logic [3:0]  m_strb,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic        m_gnt,
    input  logic        m_recv,
    input  logic        m_error,
    input  logic [31:0] m_rdata,
    output logic        m_ack
);

    logic             lock_valid_reg;
    logic             lock_sel_reg;
    logic             winner;
    logic             sel;
    logic             sel_req;
    logic             full;
    logic             bus_grant;
    logic             fifo_head;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    mem_req_t         d_fields;
    mem_req_t         i_fields;
    mem_req_t         sel_fields;

`ifdef FRV_MEM_ARB_RR_EN
    logic rr_last_reg;

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            rr_last_reg <= FRV_MEM_ARB_I;
        end else if (bus_grant) begin
            rr_last_reg <= sel;
        end
    end

    always_comb begin
        winner = FRV_MEM_ARB_D;
        if (d_req && i_req) begin
            winner = ~rr_last_reg;
        end else if (i_req) begin
            winner = FRV_MEM_ARB_I;
        end
    end
`else
    always_comb begin
        winner = FRV_MEM_ARB_D;
        if (!d_req && i_req) begin
            winner = FRV_MEM_ARB_I;
        end
    end
`endif

    // A request left waiting on the bus pins the selection until it is granted.
    assign sel       = lock_valid_reg ? lock_sel_reg : winner;
    assign sel_req   = (sel == FRV_MEM_ARB_I) ? i_req : d_req;
    assign full      = (fifo_count == CNT_W'(OUTSTANDING));
    assign m_req     = sel_req && !full;
    assign bus_grant = m_req && m_gnt;

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            lock_valid_reg <= 1'b0;
            lock_sel_reg   <= FRV_MEM_ARB_D;
        end else if (m_req && !m_gnt) begin
            lock_valid_reg <= 1'b1;
            lock_sel_reg   <= sel;
        end else if (bus_grant) begin
            lock_valid_reg <= 1'b0;
        end
    end

    assign d_fields   = {d_wen, d_strb, d_addr, d_wdata};
    assign i_fields   = {i_wen, i_strb, i_addr, i_wdata};
    assign sel_fields = !sel_req ? '0 : ((sel == FRV_MEM_ARB_I) ? i_fields : d_fields);

    assign m_wen   = sel_fields.wen;
    assign m_strb  = sel_fields.strb;
    assign m_addr  = sel_fields.addr;
    assign m_wdata = sel_fields.wdata;

    assign d_gnt = bus_grant && (sel == FRV_MEM_ARB_D);
    assign i_gnt = bus_grant && (sel == FRV_MEM_ARB_I);

    frv_mem_arb_fifo #(
        .DEPTH (OUTSTANDING)
    ) u_owner_fifo (
        .g_clk     (g_clk),
        .g_resetn  (g_resetn),
        .push      (bus_grant),
        .push_data (sel),
        .pop       (m_recv && m_ack),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // A response with nothing outstanding is dropped: no recv, no ack.
    assign m_ack  = !fifo_empty && ((fifo_head == FRV_MEM_ARB_I) ? i_ack : d_ack);
    assign d_recv = m_recv && !fifo_empty && (fifo_head == FRV_MEM_ARB_D);
    assign i_recv = m_recv && !fifo_empty && (fifo_head == FRV_MEM_ARB_I);

    assign d_rdata = m_rdata;
    assign i_rdata = m_rdata;
    assign d_error = m_error;
    assign i_error = m_error;

endmodule

// File: tb/tb_frv_mem_arbiter.sv
// Self-checking bench for frv_mem_arbiter: directed vector table, hand-written
// reset/contention sequences and a randomized run against a queue-based model.
module tb_frv_mem_arbiter;

    localparam int OUTSTANDING = 2;
`ifdef FRV_MEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        g_clk = 1'b0;
    logic        g_resetn;
    logic        d_req, d_wen, d_gnt, d_recv, d_error, d_ack;
    logic [3:0]  d_strb;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic        i_req, i_wen, i_gnt, i_recv, i_error, i_ack;
    logic [3:0]  i_strb;
    logic [31:0] i_addr, i_wdata, i_rdata;
    logic        m_req, m_wen, m_gnt, m_recv, m_error, m_ack;
    logic [3:0]  m_strb;
    logic [31:0] m_addr, m_wdata, m_rdata;

    int checks = 0;
    int passed = 0;

    frv_mem_arbiter #(.OUTSTANDING(OUTSTANDING)) dut (
        .g_clk(g_clk), .g_resetn(g_resetn),
        .d_req(d_req), .d_wen(d_wen), .d_strb(d_strb), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_recv(d_recv), .d_error(d_error), .d_rdata(d_rdata), .d_ack(d_ack),
        .i_req(i_req), .i_wen(i_wen), .i_strb(i_strb), .i_addr(i_addr), .i_wdata(i_wdata),
        .i_gnt(i_gnt), .i_recv(i_recv), .i_error(i_error), .i_rdata(i_rdata), .i_ack(i_ack),
        .m_req(m_req), .m_wen(m_wen), .m_strb(m_strb), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_gnt(m_gnt), .m_recv(m_recv), .m_error(m_error), .m_rdata(m_rdata), .m_ack(m_ack)
    );

    always #5 g_clk = ~g_clk;

    typedef struct {
        logic        d_req, i_req;
        logic [31:0] d_addr, i_addr;
        logic        m_gnt, m_recv;
        logic [31:0] rdata;
        logic        d_ack, i_ack;
        logic        e_m_req;
        logic [31:0] e_m_addr;
        logic        e_d_gnt, e_i_gnt, e_d_recv, e_i_recv, e_m_ack;
    } vec_t;

    vec_t vecs[18];

    function automatic vec_t mk(input logic dr, input logic ir, input logic [31:0] da, input logic [31:0] ia,
                                input logic mg, input logic mr, input logic [31:0] rd, input logic dk, input logic ik,
                                input logic emr, input logic [31:0] ema, input logic edg, input logic eig,
                                input logic edr, input logic eir, input logic emk);
        vec_t v;
        v.d_req = dr; v.i_req = ir; v.d_addr = da; v.i_addr = ia;
        v.m_gnt = mg; v.m_recv = mr; v.rdata = rd; v.d_ack = dk; v.i_ack = ik;
        v.e_m_req = emr; v.e_m_addr = ema; v.e_d_gnt = edg; v.e_i_gnt = eig;
        v.e_d_recv = edr; v.e_i_recv = eir; v.e_m_ack = emk;
        return v;
    endfunction

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic idle();
        d_req = 0; d_wen = 0; d_strb = 0; d_addr = 0; d_wdata = 0; d_ack = 0;
        i_req = 0; i_wen = 0; i_strb = 0; i_addr = 0; i_wdata = 0; i_ack = 0;
        m_gnt = 0; m_recv = 0; m_error = 0; m_rdata = 0;
    endtask

    function automatic logic [159:0] all_outs();
        return {19'h0, m_req, m_wen, m_strb, m_addr, m_wdata, d_gnt, i_gnt, d_recv, i_recv, m_ack,
                d_rdata, i_rdata, d_error, i_error};
    endfunction

    // Reference model state: outstanding owners in issue order, lock, last grant.
    bit          owners[$];
    bit          lock_v, lock_s, rr_last;
    bit          d_pend, i_pend;

    localparam logic [31:0] A = 32'h8000_0000, B = 32'h0000_1000, C = 32'h0000_2000;
    localparam logic [31:0] E = 32'h0000_3000, F = 32'h4000_0000, G = 32'h4000_0004;

    initial begin
        vecs[0]  = mk(1,1,A,B, 1,0,32'h00,0,0, 1,A,1,0,0,0,0);
        vecs[1]  = mk(0,1,0,B, 1,0,32'h00,0,0, 1,B,0,1,0,0,0);
        vecs[2]  = mk(0,0,0,0, 0,1,32'h11,1,0, 0,0,0,0,1,0,1);
        vecs[3]  = mk(0,0,0,0, 0,1,32'h22,0,1, 0,0,0,0,0,1,1);
        vecs[4]  = mk(0,0,0,0, 0,0,32'h00,0,0, 0,0,0,0,0,0,0);
        vecs[5]  = mk(1,0,C,0, 0,0,32'h00,0,0, 1,C,0,0,0,0,0);
        vecs[6]  = mk(1,1,C,E, 0,0,32'h00,0,0, 1,C,0,0,0,0,0);
        vecs[7]  = mk(1,1,C,E, 0,0,32'h00,0,0, 1,C,0,0,0,0,0);
        vecs[8]  = mk(1,1,C,E, 1,0,32'h00,0,0, 1,C,1,0,0,0,0);
        vecs[9]  = mk(0,1,0,E, 0,0,32'h00,0,0, 1,E,0,0,0,0,0);
        vecs[10] = mk(0,1,0,E, 1,1,32'h33,1,0, 1,E,0,1,1,0,1);
        vecs[11] = mk(0,0,0,0, 0,1,32'h44,1,1, 0,0,0,0,0,1,1);
        vecs[12] = mk(0,0,0,0, 0,1,32'h55,1,1, 0,0,0,0,0,0,0);
        vecs[13] = mk(1,0,F,0, 1,0,32'h00,0,0, 1,F,1,0,0,0,0);
        vecs[14] = mk(1,0,G,0, 1,0,32'h00,0,0, 1,G,1,0,0,0,0);
        vecs[15] = mk(0,1,0,E, 1,0,32'h00,0,0, 0,E,0,0,0,0,0);
        vecs[16] = mk(0,1,0,E, 1,1,32'h66,1,0, 0,E,0,0,1,0,1);
        vecs[17] = mk(0,1,0,E, 1,0,32'h00,0,0, 1,E,0,1,0,0,0);

        idle();
        g_resetn = 1'b0;
        @(negedge g_clk);
        check("reset_idle", all_outs(), 160'h0);
        @(negedge g_clk);
        g_resetn = 1'b1;

        // Directed vectors: priority, responses, lock hold, same-cycle push/pop, full masking.
        for (int k = 0; k < 18; k++) begin
            @(posedge g_clk); #1;
            idle();
            d_req = vecs[k].d_req; i_req = vecs[k].i_req;
            d_addr = vecs[k].d_addr; i_addr = vecs[k].i_addr;
            m_gnt = vecs[k].m_gnt; m_recv = vecs[k].m_recv; m_rdata = vecs[k].rdata;
            d_ack = vecs[k].d_ack; i_ack = vecs[k].i_ack;
            @(negedge g_clk);
            check($sformatf("vec%0d", k),
                  {122'h0, m_req, m_addr, d_gnt, i_gnt, d_recv, i_recv, m_ack},
                  {122'h0, vecs[k].e_m_req, vecs[k].e_m_addr, vecs[k].e_d_gnt, vecs[k].e_i_gnt,
                   vecs[k].e_d_recv, vecs[k].e_i_recv, vecs[k].e_m_ack});
            check($sformatf("vec%0d_rdata", k), {128'h0, d_rdata}, {128'h0, vecs[k].rdata});
            $display("vec %0d: m_req=%b m_addr=%h gnt=%b%b recv=%b%b m_ack=%b",
                     k, m_req, m_addr, d_gnt, i_gnt, d_recv, i_recv, m_ack);
        end

        // Reset with two outstanding: FIFO clears immediately, later responses dropped.
        @(posedge g_clk); #1;
        idle();
        m_recv = 1; d_ack = 1; i_ack = 1; m_rdata = 32'h77;
        #2 g_resetn = 1'b0;
        #1 check("rst_async", {156'h0, d_recv, i_recv, m_ack, m_req}, 160'h0);
        @(negedge g_clk);
        g_resetn = 1'b1;
        @(posedge g_clk); #1;
        @(negedge g_clk);
        check("rst_drop", {156'h0, d_recv, i_recv, m_ack, m_req}, 160'h0);
        $display("reset: recv=%b%b m_ack=%b", d_recv, i_recv, m_ack);
        @(posedge g_clk); #1;
        idle(); i_req = 1; i_addr = E;
        @(negedge g_clk);
        check("rst_cnt", {127'h0, m_req, m_addr}, {127'h0, 1'b1, E});
        @(posedge g_clk); #1;
        m_gnt = 1;
        @(negedge g_clk);
        check("rst_gnt", {158'h0, d_gnt, i_gnt}, {158'h0, 2'b01});

        // Continuous contention with immediate responses.
        @(posedge g_clk); #1;
        idle();
        g_resetn = 1'b0;
        @(negedge g_clk);
        g_resetn = 1'b1;
        begin
            logic [3:0] pat;
            logic       prev;
            pat  = RR ? 4'b1010 : 4'b0000;
            prev = 1'b0;
            for (int k = 0; k < 4; k++) begin
                @(posedge g_clk); #1;
                d_req = 1; i_req = 1; d_addr = A; i_addr = B;
                m_gnt = 1; m_recv = (k > 0); d_ack = 1; i_ack = 1; m_rdata = 32'(k);
                @(negedge g_clk);
                check($sformatf("contend%0d", k),
                      {156'h0, d_gnt, i_gnt, d_recv, i_recv},
                      {156'h0, !pat[k], pat[k], (k > 0) && !prev, (k > 0) && prev});
                $display("contend %0d: gnt=%b%b recv=%b%b", k, d_gnt, i_gnt, d_recv, i_recv);
                prev = pat[k];
            end
        end

        // Randomized run against the queue model.
        @(posedge g_clk); #1;
        idle();
        g_resetn = 1'b0;
        owners.delete();
        lock_v = 0; lock_s = 0; rr_last = 1; d_pend = 0; i_pend = 0;
        @(negedge g_clk);
        g_resetn = 1'b1;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            bit          s, sreq, full, empty, head, e_mreq, e_mack, grant;
            logic [68:0] e_fields;
            @(posedge g_clk); #1;
            if (!d_pend && $urandom_range(0, 2) == 0) begin
                d_pend = 1; d_addr = $urandom; d_wdata = $urandom;
                d_wen = 1'($urandom_range(0, 1)); d_strb = 4'($urandom_range(0, 15));
            end
            if (!i_pend && $urandom_range(0, 2) == 0) begin
                i_pend = 1; i_addr = $urandom; i_wdata = $urandom;
                i_wen = 1'($urandom_range(0, 1)); i_strb = 4'($urandom_range(0, 15));
            end
            d_req = d_pend; i_req = i_pend;
            m_gnt = ($urandom_range(0, 3) != 0);
            m_recv = (owners.size() != 0) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 15) == 0);
            m_rdata = $urandom; m_error = 1'($urandom_range(0, 1));
            d_ack = 1'($urandom_range(0, 1)); i_ack = 1'($urandom_range(0, 1));
            @(negedge g_clk);

            if (lock_v) s = lock_s;
            else if (d_req && i_req) s = RR ? !rr_last : 1'b0;
            else s = i_req;
            sreq     = s ? i_req : d_req;
            full     = (owners.size() >= OUTSTANDING);
            empty    = (owners.size() == 0);
            head     = empty ? 1'b0 : owners[0];
            e_mreq   = sreq && !full;
            e_fields = !sreq ? 69'h0 : (s ? {i_wen, i_strb, i_addr, i_wdata} : {d_wen, d_strb, d_addr, d_wdata});
            e_mack   = !empty && (head ? i_ack : d_ack);
            grant    = e_mreq && m_gnt;
            check($sformatf("rand%0d", cyc), all_outs(),
                  {19'h0, e_mreq, e_fields, grant && !s, grant && s,
                   m_recv && !empty && !head, m_recv && !empty && head, e_mack,
                   m_rdata, m_rdata, m_error, m_error});
            if (grant) $display("rand %0d: grant %s addr=%h", cyc, s ? "I" : "D", m_addr);

            if (m_recv && e_mack) void'(owners.pop_front());
            if (grant) begin
                owners.push_back(s);
                lock_v = 0; rr_last = s;
                if (s) i_pend = 0; else d_pend = 0;
            end else if (e_mreq) begin
                lock_v = 1; lock_s = s;
            end
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
